// File: rtl/mask_pair_streamer_if.sv
// Block-offer / beat-stream bundle for mask_pair_streamer.
// slave is the streamer's view; master is the producer/consumer side.
interface mask_pair_streamer_if;
    logic         ivalid;
    logic         oready;
    logic [15:0]  bitmaskW;
    logic [15:0]  bitmaskA;
    logic [127:0] dataW;
    logic [127:0] dataA;
    logic         ovalid;
    logic         iready;
    logic [7:0]   odataW;
    logic [7:0]   odataA;
    logic [3:0]   oindex;
    logic         olast;
    logic         oempty;
    logic [4:0]   ocount;

    modport slave (
        input  ivalid, bitmaskW, bitmaskA, dataW, dataA, iready,
        output oready, ovalid, odataW, odataA, oindex, olast, oempty, ocount
    );

    modport master (
        output ivalid, bitmaskW, bitmaskA, dataW, dataA, iready,
        input  oready, ovalid, odataW, odataA, oindex, olast, oempty, ocount
    );
endinterface

// File: rtl/mask_pair_streamer.sv
// Streams the byte pairs of lanes set in both presence masks, lowest lane first.
// MASK_PAIR_STREAMER_EMPTY_BEAT_EN: a zero-match block emits one oempty beat.
module mask_pair_streamer (
    input  logic                  clock,
    input  logic                  resetn,
    mask_pair_streamer_if.slave   bus
);

    typedef enum logic {IDLE, STREAM} streamState_t;

    streamState_t state, nextState;
    logic [15:0]  remMask;
    logic [15:0]  matchMask;
    logic [127:0] dataWReg;
    logic [127:0] dataAReg;
    logic [4:0]   countReg;
    logic [4:0]   matchCount;
    logic [3:0]   lowIdx;
    logic         accept;
    logic         beatTaken;
    logic         isLast;
`ifdef MASK_PAIR_STREAMER_EMPTY_BEAT_EN
    logic         emptyReg;
`endif

    assign matchMask = bus.bitmaskW & bus.bitmaskA;
    assign accept    = bus.ivalid && bus.oready;
    assign beatTaken = bus.ovalid && bus.iready;

    always_comb begin
        matchCount = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            matchCount = matchCount + 5'(matchMask[i]);
        end
    end

    // Lowest set bit of the remaining mask selects the current lane.
    always_comb begin
        lowIdx = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (remMask[i-1]) begin
                lowIdx = 4'(i-1);
            end
        end
    end

    always_comb begin
        isLast = (remMask != '0) && ((remMask & (remMask - 16'd1)) == '0);
`ifdef MASK_PAIR_STREAMER_EMPTY_BEAT_EN
        isLast = isLast || emptyReg;
`endif
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MASK_PAIR_STREAMER_EMPTY_BEAT_EN
                    nextState = STREAM;
`else
                    if (matchMask != '0) begin
                        nextState = STREAM;
                    end
`endif
                end
            end
            STREAM: begin
                if (beatTaken && isLast) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Beat outputs come only from registers; all zero outside STREAM.
    always_comb begin
        bus.oready = resetn && (state == IDLE);
        bus.ovalid = 1'b0;
        bus.odataW = '0;
        bus.odataA = '0;
        bus.oindex = '0;
        bus.olast  = 1'b0;
        bus.oempty = 1'b0;
        bus.ocount = '0;
        if (state == STREAM) begin
            bus.ovalid = 1'b1;
            bus.odataW = dataWReg[{lowIdx, 3'b000} +: 8];
            bus.odataA = dataAReg[{lowIdx, 3'b000} +: 8];
            bus.oindex = lowIdx;
            bus.olast  = isLast;
            bus.ocount = countReg;
`ifdef MASK_PAIR_STREAMER_EMPTY_BEAT_EN
            bus.oempty = emptyReg;
            if (emptyReg) begin
                bus.odataW = '0;
                bus.odataA = '0;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            remMask  <= '0;
            dataWReg <= '0;
            dataAReg <= '0;
            countReg <= '0;
`ifdef MASK_PAIR_STREAMER_EMPTY_BEAT_EN
            emptyReg <= 1'b0;
`endif
        end else if (accept) begin
            remMask  <= matchMask;
            dataWReg <= bus.dataW;
            dataAReg <= bus.dataA;
            countReg <= matchCount;
`ifdef MASK_PAIR_STREAMER_EMPTY_BEAT_EN
            emptyReg <= (matchMask == '0);
`endif
        end else if (beatTaken) begin
            remMask  <= remMask & (remMask - 16'd1);
`ifdef MASK_PAIR_STREAMER_EMPTY_BEAT_EN
            emptyReg <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mask_pair_streamer.sv
// Directed self-checking bench for mask_pair_streamer.
module tb_mask_pair_streamer;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [127:0] rampW;
    logic [127:0] rampA;

    always #5 clock = ~clock;

    mask_pair_streamer_if bus();

    mask_pair_streamer dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // {ovalid, oindex, odataW, odataA, ocount, olast, oempty}
    function automatic logic [27:0] beatExp(input logic [3:0] idx, input logic [7:0] dw,
                                            input logic [7:0] da, input logic [4:0] cnt,
                                            input logic last, input logic empty);
        return {1'b1, idx, dw, da, cnt, last, empty};
    endfunction

    function automatic logic [27:0] beatObs();
        return {bus.ovalid, bus.oindex, bus.odataW, bus.odataA, bus.ocount, bus.olast, bus.oempty};
    endfunction

    task automatic offer(input logic [15:0] w, input logic [15:0] a,
                         input logic [127:0] dw, input logic [127:0] da);
        @(negedge clock);
        bus.ivalid   = 1'b1;
        bus.bitmaskW = w;
        bus.bitmaskA = a;
        bus.dataW    = dw;
        bus.dataA    = da;
        @(negedge clock);
        bus.ivalid   = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({bus.oready, beatObs()} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", {bus.oready, beatObs()}, 29'd0);
        end
        @(negedge clock);
        checks++;
        if ({bus.oready, beatObs()} !== 29'd0) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", {bus.oready, beatObs()}, 29'd0);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if ({bus.oready, bus.ovalid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got=%b exp=10", {bus.oready, bus.ovalid});
        end
    endtask

    task automatic test_full_block;
        bus.iready = 1'b1;
        offer(16'hFFFF, 16'hFFFF, rampW, rampA);
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (beatObs() !== beatExp(4'(b), 8'(b), 8'(8'h10 + b), 5'd16, 1'(b == 15), 1'b0)) begin
                errors++;
                $display("FAIL full_beat%0d got=%h exp=%h", b, beatObs(),
                         beatExp(4'(b), 8'(b), 8'(8'h10 + b), 5'd16, 1'(b == 15), 1'b0));
            end
            @(negedge clock);
        end
        checks++;
        if ({bus.oready, bus.ovalid} !== 2'b10) begin
            errors++;
            $display("FAIL full_idle got=%b exp=10", {bus.oready, bus.ovalid});
        end
    endtask

    task automatic test_sparse;
        logic [3:0] idxList [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd12, 4'd13, 4'd14, 4'd15};
        bus.iready = 1'b1;
        offer(16'hF00F, 16'hFFFF, rampW, rampA);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (beatObs() !== beatExp(idxList[j], {4'h0, idxList[j]}, {4'h1, idxList[j]},
                                      5'd8, 1'(j == 7), 1'b0)) begin
                errors++;
                $display("FAIL sparse_beat%0d got=%h exp=%h", j, beatObs(),
                         beatExp(idxList[j], {4'h0, idxList[j]}, {4'h1, idxList[j]}, 5'd8, 1'(j == 7), 1'b0));
            end
            @(negedge clock);
        end
        checks++;
        if ({bus.oready, bus.ovalid} !== 2'b10) begin
            errors++;
            $display("FAIL sparse_idle got=%b exp=10", {bus.oready, bus.ovalid});
        end
    endtask

    task automatic test_backpressure;
        bus.iready = 1'b0;
        offer(16'h0101, 16'h0101, rampW, rampA);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (beatObs() !== beatExp(4'd0, 8'h00, 8'h10, 5'd2, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h exp=%h", c, beatObs(),
                         beatExp(4'd0, 8'h00, 8'h10, 5'd2, 1'b0, 1'b0));
            end
            if (c == 3) bus.iready = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (beatObs() !== beatExp(4'd8, 8'h08, 8'h18, 5'd2, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL stall_last got=%h exp=%h", beatObs(), beatExp(4'd8, 8'h08, 8'h18, 5'd2, 1'b1, 1'b0));
        end
        @(negedge clock);
        checks++;
        if ({bus.oready, bus.ovalid} !== 2'b10) begin
            errors++;
            $display("FAIL stall_idle got=%b exp=10", {bus.oready, bus.ovalid});
        end
    endtask

    task automatic test_zero_match;
        bus.iready = 1'b1;
        offer(16'hFFFF, 16'h0000, rampW, rampA);
`ifdef MASK_PAIR_STREAMER_EMPTY_BEAT_EN
        checks++;
        if ({bus.oready, beatObs()} !== {1'b0, beatExp(4'd0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b1)}) begin
            errors++;
            $display("FAIL zero_empty_beat got=%h exp=%h", {bus.oready, beatObs()},
                     {1'b0, beatExp(4'd0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b1)});
        end
        @(negedge clock);
`endif
        checks++;
        if ({bus.oready, beatObs()} !== {1'b1, 28'd0}) begin
            errors++;
            $display("FAIL zero_idle got=%h exp=%h", {bus.oready, beatObs()}, {1'b1, 28'd0});
        end
        @(negedge clock);
        checks++;
        if ({bus.oready, bus.ovalid} !== 2'b10) begin
            errors++;
            $display("FAIL zero_stay_idle got=%b exp=10", {bus.oready, bus.ovalid});
        end
    endtask

    task automatic test_reset_midstream;
        bus.iready = 1'b1;
        offer(16'hFFFF, 16'hFFFF, rampW, rampA);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (beatObs() !== beatExp(4'(b), 8'(b), 8'(8'h10 + b), 5'd16, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL midrst_beat%0d got=%h exp=%h", b, beatObs(),
                         beatExp(4'(b), 8'(b), 8'(8'h10 + b), 5'd16, 1'b0, 1'b0));
            end
            if (b < 2) @(negedge clock);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.oready, beatObs()} !== 29'd0) begin
            errors++;
            $display("FAIL midrst_cleared got=%h exp=%h", {bus.oready, beatObs()}, 29'd0);
        end
        @(negedge clock);
        resetn = 1'b1;
        #1;
        checks++;
        if ({bus.oready, bus.ovalid} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_release got=%b exp=10", {bus.oready, bus.ovalid});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (bus.ovalid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_nobeat%0d got=%b exp=0", c, bus.ovalid);
            end
        end
    endtask

    task automatic test_ivalid_in_stream;
        int waitCycles;
        bus.iready = 1'b1;
        @(negedge clock);
        bus.ivalid   = 1'b1;
        bus.bitmaskW = 16'h0003;
        bus.bitmaskA = 16'h0003;
        bus.dataW    = rampW;
        bus.dataA    = rampA;
        @(negedge clock);
        bus.bitmaskW = 16'hFFFF;
        bus.bitmaskA = 16'hFFFF;
        bus.dataW    = rampA;
        bus.dataA    = rampW;
        checks++;
        if ({bus.oready, beatObs()} !== {1'b0, beatExp(4'd0, 8'h00, 8'h10, 5'd2, 1'b0, 1'b0)}) begin
            errors++;
            $display("FAIL busy_beat0 got=%h exp=%h", {bus.oready, beatObs()},
                     {1'b0, beatExp(4'd0, 8'h00, 8'h10, 5'd2, 1'b0, 1'b0)});
        end
        @(negedge clock);
        checks++;
        if ({bus.oready, beatObs()} !== {1'b0, beatExp(4'd1, 8'h01, 8'h11, 5'd2, 1'b1, 1'b0)}) begin
            errors++;
            $display("FAIL busy_beat1 got=%h exp=%h", {bus.oready, beatObs()},
                     {1'b0, beatExp(4'd1, 8'h01, 8'h11, 5'd2, 1'b1, 1'b0)});
        end
        @(negedge clock);
        checks++;
        if ({bus.oready, bus.ovalid} !== 2'b10) begin
            errors++;
            $display("FAIL busy_idle got=%b exp=10", {bus.oready, bus.ovalid});
        end
        @(negedge clock);
        bus.ivalid = 1'b0;
        checks++;
        if ({bus.oready, beatObs()} !== {1'b0, beatExp(4'd0, 8'h10, 8'h00, 5'd16, 1'b0, 1'b0)}) begin
            errors++;
            $display("FAIL busy_next_block got=%h exp=%h", {bus.oready, beatObs()},
                     {1'b0, beatExp(4'd0, 8'h10, 8'h00, 5'd16, 1'b0, 1'b0)});
        end
        waitCycles = 0;
        while (bus.ovalid === 1'b1 && waitCycles < 40) begin
            @(negedge clock);
            waitCycles++;
        end
        checks++;
        if ({bus.oready, bus.ovalid} !== 2'b10) begin
            errors++;
            $display("FAIL busy_drain got=%b exp=10 after %0d cycles", {bus.oready, bus.ovalid}, waitCycles);
        end
    endtask

    initial begin
        bus.ivalid   = 1'b0;
        bus.bitmaskW = '0;
        bus.bitmaskA = '0;
        bus.dataW    = '0;
        bus.dataA    = '0;
        bus.iready   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rampW[8*i +: 8] = 8'(i);
            rampA[8*i +: 8] = 8'(8'h10 + i);
        end
        test_reset;
        test_full_block;
        test_sparse;
        test_backpressure;
        test_zero_match;
        test_reset_midstream;
        test_ivalid_in_stream;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
